// File: rtl/seq_adder_pkg.sv
// -----------------------------------------------------------------------------
// seq_adder_pkg
// Shared definitions for the multi-cycle adder: FSM state encoding and the
// step-counter width helper.
// -----------------------------------------------------------------------------
package seq_adder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Counter must hold 0..steps-1. The extra bit keeps steps==1 at width 1.
    function automatic int step_cnt_w(input int steps);
        return $clog2(steps) + 1;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// -----------------------------------------------------------------------------
// adder_chunk
// Purely combinational CHUNK-bit ripple adder built from full-adder cells.
// Ports:
//   a, b  : CHUNK-bit addends
//   cin   : carry into bit 0
//   s     : CHUNK-bit sum
//   cout  : carry out of the top cell
// -----------------------------------------------------------------------------
module adder_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[CHUNK];

endmodule

// File: rtl/seq_adder.sv
// -----------------------------------------------------------------------------
// seq_adder
// Multi-cycle adder: adds two WIDTH-bit operands plus carry-in, CHUNK bits per
// clock, reusing one adder_chunk with a registered carry between steps.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous, active-high reset
//   start    : request, sampled only while idle
//   a, b     : operands, sampled on accepted start
//   cin      : carry-in, sampled on accepted start
//   busy     : high while an addition is in progress
//   done     : one-cycle pulse, result registers just updated
//   sum      : WIDTH-bit result, held between completions
//   cout     : unsigned carry-out (the 2^WIDTH bit)
//   overflow : two's-complement signed overflow
// -----------------------------------------------------------------------------
module seq_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int STEPS = WIDTH / CHUNK;
    localparam int CNT_W = step_cnt_w(STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_psum;
    logic [CNT_W-1:0] r_step;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [CHUNK-1:0] w_s;
    logic             w_cout;
    logic [WIDTH-1:0] w_psum_next;

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (r_a[CHUNK-1:0]),
        .b    (r_b[CHUNK-1:0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    // New chunk enters at the MSB end; after STEPS shifts the first chunk
    // computed has reached bit 0. Written as a shift of the concatenation so
    // it also covers CHUNK == WIDTH without an empty slice.
    assign w_psum_next = WIDTH'({w_s, r_psum} >> CHUNK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_psum  <= '0;
            r_step  <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_psum  <= '0;
                        r_step  <= '0;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_carry <= w_cout;
                    r_psum  <= w_psum_next;
                    r_step  <= r_step + CNT_W'(1);
                    if (r_step == LAST_STEP) begin
                        r_sum   <= w_psum_next;
                        r_cout  <= w_cout;
                        // Signed overflow: like-signed operands, result sign differs.
                        r_ovf   <= (r_a_msb == r_b_msb) &&
                                   (w_psum_next[WIDTH-1] != r_a_msb);
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = (r_state == RUN);
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_seq_adder.sv
// -----------------------------------------------------------------------------
// tb_seq_adder
// Self-checking bench for seq_adder: table-driven 8-bit vectors (CHUNK=2),
// hand-written reset/handshake sequences, and exhaustive 4-bit runs with
// CHUNK=1 and CHUNK=4.
// -----------------------------------------------------------------------------
module tb_seq_adder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // WIDTH=8, CHUNK=2 instance
    logic       st8;
    logic [7:0] a8, b8;
    logic       ci8;
    logic       busy8, done8, cout8, ov8;
    logic [7:0] sum8;

    seq_adder #(.WIDTH(8), .CHUNK(2)) u_add8 (
        .clk(clk), .reset(rst), .start(st8), .a(a8), .b(b8), .cin(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ov8)
    );

    // WIDTH=4 instances, CHUNK=1 and CHUNK=4, sharing operand inputs
    logic       st4a, st4b;
    logic [3:0] a4, b4;
    logic       ci4;
    logic       busy4a, done4a, cout4a, ov4a;
    logic [3:0] sum4a;
    logic       busy4b, done4b, cout4b, ov4b;
    logic [3:0] sum4b;

    seq_adder #(.WIDTH(4), .CHUNK(1)) u_add4_c1 (
        .clk(clk), .reset(rst), .start(st4a), .a(a4), .b(b4), .cin(ci4),
        .busy(busy4a), .done(done4a), .sum(sum4a), .cout(cout4a), .overflow(ov4a)
    );

    seq_adder #(.WIDTH(4), .CHUNK(4)) u_add4_c4 (
        .clk(clk), .reset(rst), .start(st4b), .a(a4), .b(b4), .cin(ci4),
        .busy(busy4b), .done(done4b), .sum(sum4b), .cout(cout4b), .overflow(ov4b)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the accepting edge.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
        a8  = a;
        b8  = b;
        ci8 = c;
        st8 = 1'b1;
        tick();
        st8 = 1'b0;
    endtask

    // Cycles from the accepting edge until done is seen; -1 on timeout.
    task automatic wait8(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done8) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run4(input bit sel, input logic [3:0] a, input logic [3:0] b,
                        input logic c, output int lat);
        a4  = a;
        b4  = b;
        ci4 = c;
        if (sel) st4b = 1'b1;
        else     st4a = 1'b1;
        tick();
        st4a = 1'b0;
        st4b = 1'b0;
        lat  = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if ((sel ? done4b : done4a) == 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  seen;

        vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[8] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

        rst  = 1'b1;
        st8  = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        st4a = 1'b0; st4b = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum",  32'(sum8),  32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);
        chk("rst_ovf",  32'(ov8),   32'd0);
        chk("rst_busy4", 32'({busy4a, busy4b}), 32'd0);
        rst = 1'b0;
        tick();

        // Table-driven 8-bit vectors
        for (int i = 0; i < 9; i++) begin
            start8(vecs[i].a, vecs[i].b, vecs[i].cin);
            chk($sformatf("v%0d_busy", i), 32'(busy8), 32'd1);
            wait8(lat);
            chk($sformatf("v%0d_lat", i),  32'(lat),   32'd4);
            chk($sformatf("v%0d_sum", i),  32'(sum8),  32'(vecs[i].sum));
            chk($sformatf("v%0d_cout", i), 32'(cout8), 32'(vecs[i].cout));
            chk($sformatf("v%0d_ovf", i),  32'(ov8),   32'(vecs[i].ovf));
            chk($sformatf("v%0d_busy_done", i), 32'(busy8), 32'd0);
            tick();
            chk($sformatf("v%0d_done_pulse", i), 32'(done8), 32'd0);
            chk($sformatf("v%0d_hold", i), 32'(sum8), 32'(vecs[i].sum));
        end

        // Reset two cycles into an add: aborted, outputs cleared, no done.
        start8(8'h3C, 8'h0F, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy8), 32'd0);
        chk("mid_rst_sum",  32'(sum8),  32'd0);
        chk("mid_rst_cout", 32'(cout8), 32'd0);
        chk("mid_rst_ovf",  32'(ov8),   32'd0);
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done8 || busy8) seen = 1'b1;
        end
        chk("mid_rst_no_done", 32'(seen), 32'd0);
        chk("mid_rst_sum_after", 32'(sum8), 32'd0);

        // start while busy is ignored
        start8(8'h3C, 8'h0F, 1'b0);
        tick();
        a8  = 8'h11;
        b8  = 8'h00;
        st8 = 1'b1;
        tick();
        st8 = 1'b0;
        tick();
        chk("ign_no_early_done", 32'(done8), 32'd0);
        tick();
        chk("ign_done", 32'(done8), 32'd1);
        chk("ign_sum",  32'(sum8),  32'h4B);

        // Back-to-back: start in the done cycle, previous sum held meanwhile.
        start8(8'h01, 8'h02, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) begin
                chk($sformatf("b2b_hold_%0d", k), 32'(sum8),  32'h4B);
                chk($sformatf("b2b_done_%0d", k), 32'(done8), 32'd0);
            end else begin
                chk("b2b_done", 32'(done8), 32'd1);
                chk("b2b_sum",  32'(sum8),  32'h03);
            end
        end
        tick();

        // Exhaustive 4-bit, CHUNK=1 (4 steps) then CHUNK=4 (1 step)
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 512; i++) begin
                logic [8:0] iv;
                logic [4:0] exp_v;
                logic       exp_ov;
                logic [3:0] got_s;
                logic       got_c, got_o;
                iv    = 9'(i);
                exp_v = 5'(iv[3:0]) + 5'(iv[7:4]) + 5'(iv[8]);
                exp_ov = (iv[3] == iv[7]) && (exp_v[3] != iv[3]);
                run4(s[0], iv[3:0], iv[7:4], iv[8], lat);
                got_s = s[0] ? sum4b  : sum4a;
                got_c = s[0] ? cout4b : cout4a;
                got_o = s[0] ? ov4b   : ov4a;
                chk($sformatf("x4_c%0d_%0d_lat", s ? 4 : 1, i), 32'(lat), s ? 32'd1 : 32'd4);
                chk($sformatf("x4_c%0d_%0d_sum", s ? 4 : 1, i), 32'({got_c, got_s}), 32'(exp_v));
                chk($sformatf("x4_c%0d_%0d_ovf", s ? 4 : 1, i), 32'(got_o), 32'(exp_ov));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
